// File: rtl/pipeline_stage_skid_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding and default widths.
// The state is a pure function of the two entry valid bits, so it is decoded rather than stored.
package pipeline_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } stage_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 11;
    localparam int DEF_CNT_W  = 16;

    // A skid entry can only exist behind a main entry, so skid_v alone implies FULL.
    function automatic stage_state_e decode_state(input logic main_v, input logic skid_v);
        if (skid_v) begin
            return ST_FULL;
        end
        if (main_v) begin
            return ST_BUSY;
        end
        return ST_EMPTY;
    endfunction

endpackage

// File: rtl/pipeline_stage_skid_if.sv
// Valid/ready stage link: data and ctrl move when valid and ready are both high on a rising
// clock edge; valid must not depend combinationally on ready, and ready is registered here.
interface pipeline_stage_skid_if
    import pipeline_stage_skid_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipeline_stage_skid_entry_reg.sv
// One pipeline entry {valid, ctrl, data}: load and clear enables, clear wins, async reset to zero.
module pipe_entry_reg #(
    parameter int W = 44
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clear_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/pipeline_stage_skid.sv
// Elastic pipeline register with a main + skid entry, registered upstream ready, global hold,
// synchronous flush with bubble insertion and a saturating stall-cycle counter.
module pipeline_stage_skid
    import pipeline_stage_skid_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  busy_wait_i,
    input  logic                  flush_i,
    pipeline_stage_skid_if.slave  up_if,
    pipeline_stage_skid_if.master dn_if,
    output logic [CNT_W-1:0]      stall_count_o,
    output stage_state_e          state_o
);
    localparam int ENT_W = DATA_W + CTRL_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ENT_W-1:0] main_q;
    logic [ENT_W-1:0] skid_q;
    logic [ENT_W-1:0] in_ent;
    logic [ENT_W-1:0] main_d;

    logic main_load, main_clear, skid_load, skid_clear, main_from_skid;
    logic main_v, skid_v;
    logic hold, acc, pop, stall;
    logic in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    stage_state_e state, state_d;

    assign in_ent = {1'b1, up_if.ctrl, up_if.data};
    assign main_v = main_q[ENT_W-1];
    assign skid_v = skid_q[ENT_W-1];
    assign state  = decode_state(main_v, skid_v);

    assign hold = busy_wait_i;
    assign acc  = up_if.valid & in_ready_q & ~hold & ~flush_i;
    assign pop  = main_v & dn_if.ready & ~hold & ~flush_i;

    // Flush is evaluated ahead of the state decode so it also overrides a hold.
    always_comb begin
        state_d        = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_d    = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        main_load = 1'b1;
                        state_d   = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (acc && pop) begin
                        main_load = 1'b1;
                    end else if (acc) begin
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end else if (pop) begin
                        main_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = ST_BUSY;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = ST_EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    assign main_d = main_from_skid ? skid_q : in_ent;

    pipe_entry_reg #(.W(ENT_W)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (main_load),
        .clear_i (main_clear),
        .d_i     (main_d),
        .q_o     (main_q)
    );

    pipe_entry_reg #(.W(ENT_W)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .d_i     (in_ent),
        .q_o     (skid_q)
    );

    assign stall = (main_v & ~dn_if.ready) | busy_wait_i;
    assign cnt_d = (stall && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign up_if.ready   = in_ready_q;
    assign dn_if.valid   = main_v;
    assign dn_if.data    = main_q[DATA_W-1:0];
    assign dn_if.ctrl    = main_v ? main_q[DATA_W +: CTRL_W] : '0;
    assign stall_count_o = cnt_q;
    assign state_o       = state;
endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: a queue-based reference model of the stage (at most two held
// entries, FIFO order) drives expectations; a second instance with a 4-bit counter shares stimulus.
module tb_pipeline_stage_skid;
  import pipeline_stage_skid_pkg::*;

  localparam int DW = 32;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bw = 1'b0;
  logic fl = 1'b0;
  logic [15:0] cnt16;
  logic [3:0] cnt4;
  stage_state_e st16, st4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipeline_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();
  pipeline_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up2_if ();
  pipeline_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn2_if ();

  assign up2_if.valid = up_if.valid;
  assign up2_if.data  = up_if.data;
  assign up2_if.ctrl  = up_if.ctrl;
  assign dn2_if.ready = dn_if.ready;

  pipeline_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .busy_wait_i(bw), .flush_i(fl),
    .up_if(up_if), .dn_if(dn_if), .stall_count_o(cnt16), .state_o(st16)
  );

  pipeline_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .busy_wait_i(bw), .flush_i(fl),
    .up_if(up2_if), .dn_if(dn2_if), .stall_count_o(cnt4), .state_o(st4)
  );

  // Reference model: held entries {ctrl,data} in arrival order, registered ready, counters.
  logic [CW+DW-1:0] exp_q[$];
  bit m_rdy = 1'b1;
  int unsigned m_cnt16 = 0;
  int unsigned m_cnt4 = 0;

  function automatic logic [CW+DW:0] model_out();
    if (exp_q.size() == 0) return '0;
    return {1'b1, exp_q[0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_rdy = 1'b1;
    m_cnt16 = 0;
    m_cnt4 = 0;
  endtask

  task automatic model_edge(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                            input bit ordy, input bit hold, input bit flush);
    bit accept;
    if ((exp_q.size() > 0 && !ordy) || hold) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (flush) begin
      exp_q.delete();
    end else if (!hold) begin
      accept = v && m_rdy;
      if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
      if (accept) exp_q.push_back({c, d});
    end
    m_rdy = (exp_q.size() < 2);
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic step(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input bit ordy, input bit hold, input bit flush);
    up_if.valid = v;
    up_if.data  = d;
    up_if.ctrl  = c;
    dn_if.ready = ordy;
    bw = hold;
    fl = flush;
    @(posedge clk);
    model_edge(v, d, c, ordy, hold, flush);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    up_if.valid = 1'b0;
    up_if.data  = '0;
    up_if.ctrl  = '0;
    dn_if.ready = 1'b0;
    bw = 1'b0;
    fl = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({dn_if.valid, dn_if.ctrl, dn_if.data, up_if.ready} !== {1'b0, 11'h0, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state got v=%b c=%h d=%h rdy=%b required 0/0/0/1",
               dn_if.valid, dn_if.ctrl, dn_if.data, up_if.ready);
    end
    n_vec++;
    if (cnt16 !== 16'd0 || cnt4 !== 4'd0) begin
      n_err++;
      $display("FAIL reset_count got %0d/%0d required 0/0", cnt16, cnt4);
    end
    step(1'b1, 32'h11, 11'h7ff, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h22, 11'h7ff, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (st16 !== ST_FULL) begin
      n_err++;
      $display("FAIL reset_prefill_state got %s required ST_FULL", st16.name());
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({dn_if.valid, dn_if.ctrl} !== 12'h0 || cnt16 !== 16'd0 || st16 !== ST_EMPTY) begin
      n_err++;
      $display("FAIL reset_async got v=%b c=%h cnt=%0d st=%s required 0/0/0/ST_EMPTY",
               dn_if.valid, dn_if.ctrl, cnt16, st16.name());
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (up_if.ready !== 1'b1 || dn_if.valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release got rdy=%b v=%b required 1/0", up_if.ready, dn_if.valid);
    end
  endtask

  task automatic test_streaming();
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, DW'(k), CW'($urandom), 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (dn_if.valid !== 1'b1 || dn_if.data !== DW'(k) || up_if.ready !== 1'b1) begin
        n_err++;
        $display("FAIL stream_k%0d got v=%b d=%h rdy=%b required 1/%h/1",
                 k, dn_if.valid, dn_if.data, up_if.ready, k);
      end
      n_vec++;
      if ({dn_if.valid, dn_if.ctrl, dn_if.data} !== model_out()) begin
        n_err++;
        $display("FAIL stream_model got %h required %h",
                 {dn_if.valid, dn_if.ctrl, dn_if.data}, model_out());
      end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (dn_if.valid !== 1'b0 || dn_if.ctrl !== '0 || cnt16 !== 16'd0) begin
      n_err++;
      $display("FAIL stream_drain got v=%b c=%h cnt=%0d required 0/0/0",
               dn_if.valid, dn_if.ctrl, cnt16);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] want[3];
    logic [DW-1:0] got[$];
    bit c_done;
    bit v_now;
    want[0] = 32'hA;
    want[1] = 32'hB;
    want[2] = 32'hC;
    apply_reset();
    step(1'b1, 32'hA, 11'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB, 11'h2, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (up_if.ready !== 1'b0 || dn_if.data !== 32'hA) begin
      n_err++;
      $display("FAIL bp_full got rdy=%b d=%h required 0/a", up_if.ready, dn_if.data);
    end
    step(1'b1, 32'hC, 11'h3, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (up_if.ready !== 1'b0 || dn_if.data !== 32'hA || st16 !== ST_FULL) begin
      n_err++;
      $display("FAIL bp_hold got rdy=%b d=%h st=%s required 0/a/ST_FULL",
               up_if.ready, dn_if.data, st16.name());
    end
    c_done = 1'b0;
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      if (dn_if.valid) got.push_back(dn_if.data);
      v_now = !c_done;
      if (v_now && m_rdy) c_done = 1'b1;
      step(v_now, 32'hC, 11'h3, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if ({dn_if.valid, dn_if.ctrl, dn_if.data} !== model_out()) begin
        n_err++;
        $display("FAIL bp_model got %h required %h",
                 {dn_if.valid, dn_if.ctrl, dn_if.data}, model_out());
      end
    end
    n_vec++;
    if (got.size() != 3) begin
      n_err++;
      $display("FAIL bp_count got %0d entries required 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (got[i] !== want[i]) begin
          n_err++;
          $display("FAIL bp_order idx=%0d got %h required %h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_busy_wait();
    int unsigned start;
    apply_reset();
    step(1'b1, 32'h1234, 11'h0ff, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5678, 11'h0f0, 1'b0, 1'b0, 1'b0);
    start = m_cnt16;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, CW'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n_vec++;
      if (dn_if.data !== 32'h1234 || dn_if.ctrl !== 11'h0ff || up_if.ready !== 1'b0
          || st16 !== ST_FULL) begin
        n_err++;
        $display("FAIL busy_frozen got d=%h c=%h rdy=%b st=%s required 1234/0ff/0/ST_FULL",
                 dn_if.data, dn_if.ctrl, up_if.ready, st16.name());
      end
    end
    n_vec++;
    if (cnt16 !== 16'(start + 5)) begin
      n_err++;
      $display("FAIL busy_count got %0d required %0d", cnt16, start + 5);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if ({dn_if.valid, dn_if.ctrl, dn_if.data} !== model_out()) begin
        n_err++;
        $display("FAIL busy_drain got %h required %h",
                 {dn_if.valid, dn_if.ctrl, dn_if.data}, model_out());
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    step(1'b1, 32'h1, 11'h7ff, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2, 11'h7ff, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h55, 11'h7ff, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({dn_if.valid, dn_if.ctrl, dn_if.data, up_if.ready} !== {1'b0, 11'h0, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL flush_empty got v=%b c=%h d=%h rdy=%b required 0/0/0/1",
               dn_if.valid, dn_if.ctrl, dn_if.data, up_if.ready);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (dn_if.valid !== 1'b0 || dn_if.data === 32'h55) begin
        n_err++;
        $display("FAIL flush_leak got v=%b d=%h required 0/not 55", dn_if.valid, dn_if.data);
      end
    end
    step(1'b1, 32'h3, 11'h7ff, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h4, 11'h7ff, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h55, 11'h7ff, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if (dn_if.valid !== 1'b0 || dn_if.ctrl !== '0 || up_if.ready !== 1'b1 || st16 !== ST_EMPTY) begin
      n_err++;
      $display("FAIL flush_busy got v=%b c=%h rdy=%b st=%s required 0/0/1/ST_EMPTY",
               dn_if.valid, dn_if.ctrl, up_if.ready, st16.name());
    end
    n_vec++;
    if (cnt16 !== 16'(m_cnt16) || m_cnt16 == 0) begin
      n_err++;
      $display("FAIL flush_count got %0d required %0d (nonzero)", cnt16, m_cnt16);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    step(1'b1, 32'h9, 11'h1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (cnt4 !== 4'(m_cnt4)) begin
        n_err++;
        $display("FAIL sat_step%0d got %0d required %0d", i, cnt4, m_cnt4);
      end
    end
    n_vec++;
    if (cnt4 !== 4'd15 || cnt16 !== 16'd20) begin
      n_err++;
      $display("FAIL sat_final got %0d/%0d required 15/20", cnt4, cnt16);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, CW'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
      n_vec++;
      if ({dn_if.valid, dn_if.ctrl, dn_if.data} !== model_out()
          || {dn2_if.valid, dn2_if.ctrl, dn2_if.data} !== model_out()) begin
        n_err++;
        $display("FAIL rand_out cyc=%0d got %h/%h required %h", i,
                 {dn_if.valid, dn_if.ctrl, dn_if.data},
                 {dn2_if.valid, dn2_if.ctrl, dn2_if.data}, model_out());
      end
      n_vec++;
      if (up_if.ready !== m_rdy || up2_if.ready !== m_rdy) begin
        n_err++;
        $display("FAIL rand_ready cyc=%0d got %b/%b required %b", i,
                 up_if.ready, up2_if.ready, m_rdy);
      end
      n_vec++;
      if (cnt16 !== 16'(m_cnt16) || cnt4 !== 4'(m_cnt4)) begin
        n_err++;
        $display("FAIL rand_count cyc=%0d got %0d/%0d required %0d/%0d", i,
                 cnt16, cnt4, m_cnt16, m_cnt4);
      end
    end
  endtask

  initial begin
    up_if.valid = 1'b0;
    up_if.data  = '0;
    up_if.ctrl  = '0;
    dn_if.ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_busy_wait();
    test_flush();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
